interrupt_arbiter32: RTL
========================

INTERRUPT_ARBITER32 -- requirements
Module: interrupt_arbiter32

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port resetN, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port sources, input, 32 bits: interrupt lines; bit i = source i.
REQ-004 SHALL have port writeEnable, input, 1 bit: register write strobe.
REQ-005 SHALL have port writeAddress, input, 1 bit: 0 = mask register, 1 = pending-clear register.
REQ-006 SHALL have port writeData, input, 32 bits: write data.
REQ-007 SHALL have port maskRegister, output, 32 bits: current enable mask.
REQ-008 SHALL have port pendingRegister, output, 32 bits: current pending bits.
REQ-009 SHALL have port irqRequest, output, 1 bit: interrupt request to the CPU.
REQ-010 SHALL have port irqIndex, output, 5 bits: index of the requested or in-service source.
REQ-011 SHALL have port irqAcknowledge, input, 1 bit: CPU accepts the request.
REQ-012 SHALL have port endOfInterrupt, input, 1 bit: CPU has finished the handler.

Function
REQ-013 SHALL register sources every cycle into sampled; all arbitration uses sampled, never sources directly.
REQ-014 SHALL form candidates = pendingRegister & maskRegister; winner = lowest set index; anyCandidate = |candidates.
REQ-015 SHALL implement states IDLE, REQUEST and SERVICE.
REQ-016 IDLE: if anyCandidate, SHALL latch winner into irqIndex and go to REQUEST next cycle; otherwise stay in IDLE.
REQ-017 REQUEST: irqRequest = 1; irqIndex SHALL stay stable, even if a lower-index candidate appears.
REQ-018 REQUEST with irqAcknowledge: SHALL go to SERVICE and, in edge mode, clear pending[irqIndex] on the same edge.
REQ-019 REQUEST without irqAcknowledge and candidates[irqIndex] == 0 (masked or cleared): SHALL withdraw to IDLE; irqRequest low next cycle.
REQ-020 Acknowledge and withdrawal condition in the same cycle: the acknowledge SHALL win.
REQ-021 SERVICE: irqRequest = 0 and irqIndex held; endOfInterrupt SHALL return to IDLE; no nesting.
REQ-022 irqAcknowledge outside REQUEST and endOfInterrupt outside SERVICE SHALL be ignored.
REQ-023 Write to address 0 SHALL load maskRegister = writeData on the next edge.
REQ-024 Write to address 1 SHALL clear every pending bit set in writeData (write-1-to-clear).
REQ-025 A bit set and cleared (by W1C or acknowledge) in the same cycle SHALL end up set.

Reset
REQ-026 Asserting resetN low SHALL immediately force: state IDLE, irqRequest 0, irqIndex 0, maskRegister 0, pendingRegister 0, sampled 0.
REQ-027 Reset during REQUEST or SERVICE SHALL abandon the interrupt; no acknowledge or end-of-interrupt is required afterwards.

Configuration
REQ-028 Macro INTERRUPT_ARBITER_EDGE_CAPTURE_EN SHALL select the pending mode.
- Defined: pending[i] set by a sampled 0->1 transition on source i; held until acknowledge or W1C.
- Undefined: pending = sampled (level-sensitive); W1C writes and acknowledge-clear have no effect.

Structure
REQ-029 A shared package SHALL hold the state encodings (IDLE=0, REQUEST=1, SERVICE=2), the source count 32 and the index width 5.
REQ-030 Winner selection SHALL instantiate the existing PriorityEncoder32 as the single sub-module: inputs candidates; outputs anyCandidate and winner.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- Edge mode, mask=32'h0000_0010, pulse source 4: irqRequest=1, irqIndex=4 within 3 cycles; acknowledge -> pending[4]=0, SERVICE; endOfInterrupt -> IDLE, irqRequest=0.
- Mask=32'hFFFF_FFFF, sources 32'h8000_0104 set together: irqIndex=2; after its EOI irqIndex=8; after that EOI irqIndex=31.
- In REQUEST for index 5, a write to address 0 with 0: irqRequest=0 one cycle later, pending[5] still 1.
- W1C of bit 7 in the same cycle as a new edge on source 7: pending[7]=1 afterwards.
- resetN pulsed low during SERVICE: all outputs 0 immediately; after release the block is in IDLE with maskRegister=0.
- Level mode (macro undefined), source 3 held high and masked in: re-requested after EOI; W1C of 32'h8 has no effect on pendingRegister.

Source files
------------

// File: rtl/interrupt_arbiter32_pkg.sv
// Shared definitions for the 32-source interrupt arbiter: state encodings,
// source count and index width.
package interrupt_arbiter32_pkg;

  localparam int unsigned NumSources = 32;
  localparam int unsigned IdxW       = 5;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRequest = 2'd1,
    StService = 2'd2
  } state_e;

endpackage

// File: rtl/interrupt_arbiter32_prienc.sv
// PriorityEncoder32: lowest set index wins; anyCandidate flags a non-empty input.
module PriorityEncoder32
  import interrupt_arbiter32_pkg::*;
(
  input  logic [NumSources-1:0] candidates,
  output logic                  anyCandidate,
  output logic [IdxW-1:0]       winner
);

  // Scan from the top down so the lowest set index is the last assignment
  always_comb begin
    winner = {IdxW{1'b0}};
    for (int i = NumSources - 1; i >= 0; i--) begin
      winner = candidates[i] ? IdxW'(i) : winner;
    end
    anyCandidate = |candidates;
  end

endmodule

// File: rtl/interrupt_arbiter32.sv
// 32-source interrupt arbiter with mask/W1C registers and an IDLE/REQUEST/SERVICE
// handshake. INTERRUPT_ARBITER_EDGE_CAPTURE_EN selects edge capture (else level).
module interrupt_arbiter32
  import interrupt_arbiter32_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [NumSources-1:0] sources,
  input  logic                  writeEnable,
  input  logic                  writeAddress,
  input  logic [NumSources-1:0] writeData,
  output logic [NumSources-1:0] maskRegister,
  output logic [NumSources-1:0] pendingRegister,
  output logic                  irqRequest,
  output logic [IdxW-1:0]       irqIndex,
  input  logic                  irqAcknowledge,
  input  logic                  endOfInterrupt
);

  logic [NumSources-1:0] sampled_q;
  logic [NumSources-1:0] mask_q, mask_d;
  logic [NumSources-1:0] pending_s;
  logic [NumSources-1:0] candidates_s;
  logic                  any_candidate_s;
  logic [IdxW-1:0]       winner_s;
  state_e                state_q, state_d;
  logic [IdxW-1:0]       index_q, index_d;

  assign candidates_s = pending_s & mask_q;

  PriorityEncoder32 u_prienc (
    .candidates   (candidates_s),
    .anyCandidate (any_candidate_s),
    .winner       (winner_s)
  );

  // Mask register load
  always_comb begin
    if (writeEnable && (writeAddress == 1'b0)) begin
      mask_d = writeData;
    end else begin
      mask_d = mask_q;
    end
  end

  // Arbitration handshake; acknowledge takes priority over withdrawal
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    case (state_q)
      StIdle: begin
        if (any_candidate_s) begin
          index_d = winner_s;
          state_d = StRequest;
        end else begin
          state_d = StIdle;
        end
      end
      StRequest: begin
        if (irqAcknowledge) begin
          state_d = StService;
        end else if (!candidates_s[index_q]) begin
          state_d = StIdle;
        end else begin
          state_d = StRequest;
        end
      end
      StService: begin
        if (endOfInterrupt) begin
          state_d = StIdle;
        end else begin
          state_d = StService;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Core state registers
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sampled_q <= {NumSources{1'b0}};
      mask_q    <= {NumSources{1'b0}};
      state_q   <= StIdle;
      index_q   <= {IdxW{1'b0}};
    end else begin
      sampled_q <= sources;
      mask_q    <= mask_d;
      state_q   <= state_d;
      index_q   <= index_d;
    end
  end

`ifdef INTERRUPT_ARBITER_EDGE_CAPTURE_EN
  logic [NumSources-1:0] prev_q;
  logic [NumSources-1:0] pend_q, pend_d;
  logic                  ack_clear_s;

  assign ack_clear_s = (state_q == StRequest) && irqAcknowledge;

  // Clears first, then new rising edges, so a same-cycle set survives
  always_comb begin
    pend_d = pend_q;
    if (writeEnable && (writeAddress == 1'b1)) begin
      pend_d = pend_d & ~writeData;
    end else begin
      pend_d = pend_d;
    end
    if (ack_clear_s) begin
      pend_d[index_q] = 1'b0;
    end else begin
      pend_d = pend_d;
    end
    pend_d = pend_d | (sampled_q & ~prev_q);
  end

  // Edge-capture history and pending latch
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      prev_q <= {NumSources{1'b0}};
      pend_q <= {NumSources{1'b0}};
    end else begin
      prev_q <= sampled_q;
      pend_q <= pend_d;
    end
  end

  assign pending_s = pend_q;
`else
  assign pending_s = sampled_q;
`endif

  assign maskRegister    = mask_q;
  assign pendingRegister = pending_s;
  assign irqRequest      = (state_q == StRequest);
  assign irqIndex        = index_q;

endmodule
